// File: rtl/spi_seq_pkg.sv
// Shared types and default chip-select timing for the SPI transaction sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        WAIT_RX,
        HOLD,
        GAP
    } seq_state_t;

    localparam int DEF_SETUP_CLKS = 2;
    localparam int DEF_HOLD_CLKS  = 2;
    localparam int DEF_IDLE_CLKS  = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Loadable count-down timer; expire is high during the last of 'value' cycles after a load.
module spi_seq_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/spi_txn_sequencer.sv
// Multi-byte SPI transaction sequencer: owns chip-select timing and streams bytes through
// the byte-level SPI master engine, one transaction in flight.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int  NUM_CS        = 2,
    parameter int  MAX_BYTES     = 16,
    parameter int  CS_SETUP_CLKS = DEF_SETUP_CLKS,
    parameter int  CS_HOLD_CLKS  = DEF_HOLD_CLKS,
    parameter int  CS_IDLE_CLKS  = DEF_IDLE_CLKS,
    localparam int LEN_W         = $clog2(MAX_BYTES + 1),
    localparam int SEL_W         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic [SEL_W-1:0]  i_CS_Sel,
    input  logic [LEN_W-1:0]  i_Len,
    input  logic              i_Abort,
    input  logic [7:0]        i_TX_Byte,
    output logic              o_TX_Pop,
    output logic [7:0]        o_RX_Byte,
    output logic              o_RX_Valid,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Aborted,
    output logic [7:0]        o_Eng_TX_Byte,
    output logic              o_Eng_TX_DV,
    input  logic              i_Eng_TX_Ready,
    input  logic              i_Eng_RX_DV,
    input  logic [7:0]        i_Eng_RX_Byte,
    output logic [NUM_CS-1:0] o_SPI_CS_n
);

    localparam int CNT_W = $clog2(max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS) + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] remaining;
    logic             accept;
    logic             abort_q;
    logic             abort_any;
    logic             rx_take;
    logic             tmr_load;
    logic             tmr_expire;
    logic [CNT_W-1:0] tmr_val;

    assign len_eff   = (i_Len > MAX_LEN) ? MAX_LEN : i_Len;
    assign o_Busy    = (state != IDLE) || o_Done;
    assign accept    = i_Start && !o_Busy;
    assign abort_any = abort_q || i_Abort;
    assign rx_take   = (state == WAIT_RX) && i_Eng_RX_DV;
    assign o_Aborted = abort_q;

    spi_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (i_Clk),
        .rst    (i_Rst),
        .load   (tmr_load),
        .value  (tmr_val),
        .expire (tmr_expire)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The LOAD cycle supplies the last setup clock, so SETUP itself runs one cycle short
    // and is skipped entirely when only one setup clock is required.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (len_eff != '0)) begin
                    state_next = (CS_SETUP_CLKS > 1) ? SETUP : LOAD;
                end
            end
            SETUP: begin
                if (abort_any)       state_next = HOLD;
                else if (tmr_expire) state_next = LOAD;
            end
            LOAD: begin
                if (abort_any)           state_next = HOLD;
                else if (i_Eng_TX_Ready) state_next = WAIT_RX;
            end
            WAIT_RX: begin
                if (i_Eng_RX_DV) begin
                    state_next = ((remaining == LEN_W'(1)) || abort_any) ? HOLD : LOAD;
                end
            end
            HOLD:    if (tmr_expire) state_next = GAP;
            GAP:     if (tmr_expire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_TX_Pop = (state == LOAD) && !abort_any && i_Eng_TX_Ready;
        tmr_load = (state_next != state) &&
                   ((state_next == SETUP) || (state_next == HOLD) || (state_next == GAP));
        case (state_next)
            SETUP:   tmr_val = CNT_W'(CS_SETUP_CLKS - 1);
            HOLD:    tmr_val = CNT_W'(CS_HOLD_CLKS);
            GAP:     tmr_val = CNT_W'(CS_IDLE_CLKS);
            default: tmr_val = '0;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_SPI_CS_n    <= '1;
            remaining     <= '0;
            abort_q       <= 1'b0;
            o_Done        <= 1'b0;
            o_Eng_TX_DV   <= 1'b0;
            o_Eng_TX_Byte <= 8'h00;
            o_RX_Valid    <= 1'b0;
            o_RX_Byte     <= 8'h00;
        end else begin
            o_Eng_TX_DV <= o_TX_Pop;
            if (o_TX_Pop) o_Eng_TX_Byte <= i_TX_Byte;

            o_RX_Valid <= rx_take;
            if (rx_take) begin
                o_RX_Byte <= i_Eng_RX_Byte;
                remaining <= remaining - LEN_W'(1);
            end

            o_Done <= (accept && (len_eff == '0)) || ((state == GAP) && tmr_expire);

            // Abort is remembered until the next accepted start so o_Aborted is valid at o_Done.
            if (accept)                        abort_q <= 1'b0;
            else if ((state != IDLE) && i_Abort) abort_q <= 1'b1;

            if (accept && (len_eff != '0)) begin
                o_SPI_CS_n <= ~(NUM_CS'(1) << i_CS_Sel);
                remaining  <= len_eff;
            end else if ((state == HOLD) && tmr_expire) begin
                o_SPI_CS_n <= '1;
            end
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Scoreboard bench for spi_txn_sequencer with a loopback byte-engine model (RX byte = TX byte).
module tb_spi_txn_sequencer;

    localparam int NUM_CS    = 2;
    localparam int MAX_BYTES = 16;
    localparam int SETUP_C   = 2;
    localparam int HOLD_C    = 2;
    localparam int IDLE_C    = 4;
    localparam int ENG_LAT   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [0:0] cs_sel = 1'b0;
    logic [4:0] len = '0;
    logic       abort = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_pop, rx_valid, busy, done, aborted, eng_tx_dv;
    logic [7:0] rx_byte, eng_tx_byte;
    logic [1:0] cs_n;
    logic       eng_ready = 1'b1;
    logic       eng_rx_dv = 1'b0;
    logic [7:0] eng_rx_byte = 8'h00;
    logic [7:0] eng_shift = 8'h00;
    int         eng_cnt = 0;

    typedef struct {
        logic [1:0] cs;
        int         nbytes;
        logic       aborted;
        logic       zero_len;
    } txn_t;

    txn_t       txn_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_txn_sequencer #(
        .NUM_CS        (NUM_CS),
        .MAX_BYTES     (MAX_BYTES),
        .CS_SETUP_CLKS (SETUP_C),
        .CS_HOLD_CLKS  (HOLD_C),
        .CS_IDLE_CLKS  (IDLE_C)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Start        (start),
        .i_CS_Sel       (cs_sel),
        .i_Len          (len),
        .i_Abort        (abort),
        .i_TX_Byte      (tx_byte),
        .o_TX_Pop       (tx_pop),
        .o_RX_Byte      (rx_byte),
        .o_RX_Valid     (rx_valid),
        .o_Busy         (busy),
        .o_Done         (done),
        .o_Aborted      (aborted),
        .o_Eng_TX_Byte  (eng_tx_byte),
        .o_Eng_TX_DV    (eng_tx_dv),
        .i_Eng_TX_Ready (eng_ready),
        .i_Eng_RX_DV    (eng_rx_dv),
        .i_Eng_RX_Byte  (eng_rx_byte),
        .o_SPI_CS_n     (cs_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Loopback engine: ready drops on DV, byte returns ENG_LAT cycles later, ready returns after.
    always @(posedge clk) begin
        eng_rx_dv <= 1'b0;
        if (eng_tx_dv === 1'b1) begin
            check("eng_dv_only_when_ready", {31'b0, eng_ready}, 32'd1);
            eng_ready <= 1'b0;
            eng_shift <= eng_tx_byte;
            eng_cnt   <= ENG_LAT;
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end else if (eng_cnt == 1) begin
            eng_cnt     <= 0;
            eng_rx_dv   <= 1'b1;
            eng_rx_byte <= eng_shift;
        end else begin
            eng_ready <= 1'b1;
        end
    end

    // TX byte source: a pop consumes the head at the following negedge, after the DUT sampled it.
    logic pop_seen = 1'b0;
    always @(negedge clk) begin
        if (pop_seen && (tx_q.size() > 0)) void'(tx_q.pop_front());
        pop_seen = (tx_pop === 1'b1);
        tx_byte  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end

    // Monitor / scoreboard
    logic cs_was_low = 1'b0, first_dv_pend = 1'b0, cs_seen = 1'b0;
    int   t_start = 0, t_cs_fall = 0, t_cs_rise = 0, t_rxv = 0;
    int   n_pop = 0, n_dv = 0, n_rxv = 0;
    txn_t e;
    always @(negedge clk) begin
        if (rst) begin
            cs_was_low = 1'b0; first_dv_pend = 1'b0; cs_seen = 1'b0;
            n_pop = 0; n_dv = 0; n_rxv = 0;
        end else begin
            if (start && !busy) t_start = cyc;
            if (cs_n != 2'b11) begin
                if (!cs_was_low) begin
                    t_cs_fall = cyc; first_dv_pend = 1'b1; cs_seen = 1'b1;
                end
                if (txn_q.size() == 0) check("cs_idle", {30'b0, cs_n}, 32'h3);
                else                   check("cs_pattern", {30'b0, cs_n}, {30'b0, txn_q[0].cs});
                cs_was_low = 1'b1;
            end else if (cs_was_low) begin
                cs_was_low = 1'b0;
                t_cs_rise  = cyc;
                if (n_rxv > 0) check("hold_clks", cyc - t_rxv, HOLD_C);
            end
            if (eng_tx_dv) begin
                n_dv++;
                if (first_dv_pend) begin
                    check("setup_clks", cyc - t_cs_fall, SETUP_C);
                    first_dv_pend = 1'b0;
                end
            end
            if (tx_pop) n_pop++;
            if (rx_valid) begin
                n_rxv++;
                t_rxv = cyc;
                if (rx_q.size() == 0) fail_now("rx_unexpected");
                else                  check("rx_byte", {24'b0, rx_byte}, {24'b0, rx_q.pop_front()});
            end
            if (done) begin
                if (txn_q.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    e = txn_q.pop_front();
                    check("pop_count", n_pop, e.nbytes);
                    check("eng_dv_count", n_dv, e.nbytes);
                    check("rx_valid_count", n_rxv, e.nbytes);
                    check("aborted_flag", {31'b0, aborted}, {31'b0, e.aborted});
                    if (e.zero_len) begin
                        check("zero_len_latency", cyc - t_start, 1);
                        check("zero_len_cs_untouched", {31'b0, cs_seen}, 32'd0);
                    end else begin
                        check("idle_clks", cyc - t_cs_rise, IDLE_C);
                        check("cs_high_at_done", {30'b0, cs_n}, 32'h3);
                    end
                end
                n_pop = 0; n_dv = 0; n_rxv = 0; cs_seen = 1'b0; first_dv_pend = 1'b0;
            end
        end
    end

    task automatic push_txn(input logic [1:0] cs, input int nbytes, input logic ab, input logic zl);
        txn_t t;
        t.cs = cs; t.nbytes = nbytes; t.aborted = ab; t.zero_len = zl;
        txn_q.push_back(t);
    endtask

    task automatic pulse_start(input logic s, input logic [4:0] l);
        cs_sel = s; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while ((done !== 1'b1) && (k < 400)) begin
            @(posedge clk); #1;
            k++;
        end
        if (done !== 1'b1) begin
            fail_now(name);
        end else begin
            @(posedge clk); #1;
            check("busy_drops_after_done", {31'b0, busy}, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_dv(input int n, input string name);
        int seen = 0;
        int k = 0;
        while ((seen < n) && (k < 200)) begin
            @(posedge clk); #1;
            k++;
            if (eng_tx_dv === 1'b1) seen++;
        end
        if (seen < n) fail_now(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int k;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", {30'b0, cs_n}, 32'h3);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_aborted", {31'b0, aborted}, 32'd0);
        check("rst_tx_pop", {31'b0, tx_pop}, 32'd0);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_eng_dv", {31'b0, eng_tx_dv}, 32'd0);
        check("rst_eng_byte", {24'b0, eng_tx_byte}, 32'd0);
        check("rst_rx_byte", {24'b0, rx_byte}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Len=3 on CS1, plus a start while busy that must be ignored
        tx_q.push_back(8'hA5); tx_q.push_back(8'h3C); tx_q.push_back(8'hFF);
        rx_q.push_back(8'hA5); rx_q.push_back(8'h3C); rx_q.push_back(8'hFF);
        push_txn(2'b01, 3, 1'b0, 1'b0);
        pulse_start(1'b1, 5'd3);
        k = 0;
        while ((tx_pop !== 1'b1) && (k < 50)) begin @(posedge clk); #1; k++; end
        if (tx_pop !== 1'b1) fail_now("first_pop");
        @(posedge clk); #1;
        pulse_start(1'b0, 5'd2);
        wait_done("done_len3");

        // Len=0: immediate done, CS untouched, no engine traffic
        push_txn(2'b11, 0, 1'b0, 1'b1);
        pulse_start(1'b0, 5'd0);
        wait_done("done_len0");

        // Len=4 on CS0, abort while byte 2 is in flight
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33); tx_q.push_back(8'h44);
        rx_q.push_back(8'h11); rx_q.push_back(8'h22);
        push_txn(2'b10, 2, 1'b1, 1'b0);
        pulse_start(1'b0, 5'd4);
        wait_dv(2, "abort_second_dv");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done("done_abort");
        tx_q.delete();

        // Start with abort in the same IDLE cycle: start wins, o_Aborted cleared
        tx_q.push_back(8'h00); tx_q.push_back(8'h81);
        rx_q.push_back(8'h00); rx_q.push_back(8'h81);
        push_txn(2'b10, 2, 1'b0, 1'b0);
        abort = 1'b1;
        pulse_start(1'b0, 5'd2);
        abort = 1'b0;
        wait_done("done_start_abort");

        // Len=20 clamps to MAX_BYTES
        for (int i = 0; i < MAX_BYTES; i++) begin
            b = 8'((i * 17) + 3);
            tx_q.push_back(b);
            rx_q.push_back(b);
        end
        push_txn(2'b01, MAX_BYTES, 1'b0, 1'b0);
        pulse_start(1'b1, 5'd20);
        wait_done("done_clamp");

        // Reset in the middle of byte 2
        tx_q.push_back(8'hC1); tx_q.push_back(8'hC2); tx_q.push_back(8'hC3);
        rx_q.push_back(8'hC1);
        push_txn(2'b10, 3, 1'b0, 1'b0);
        pulse_start(1'b0, 5'd3);
        wait_dv(2, "reset_second_dv");
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_cs_n", {30'b0, cs_n}, 32'h3);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        void'(txn_q.pop_front());
        tx_q.delete();
        check("rst_mid_rx_drained", rx_q.size(), 32'd0);
        repeat (10) @(posedge clk);
        #1;

        // Recovery transaction after reset
        tx_q.push_back(8'h5A);
        rx_q.push_back(8'h5A);
        push_txn(2'b01, 1, 1'b0, 1'b0);
        pulse_start(1'b1, 5'd1);
        wait_done("done_after_reset");

        check("txn_queue_empty", txn_q.size(), 32'd0);
        check("rx_queue_empty", rx_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
